// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mem_pkg
//  Brief  : Shared encodings for the RV32 memory stage: load/store funct3
//           values, result_src selections and the memory FSM state type.
//  Rev    : 1.0  initial release
// ============================================================================
package mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Write-back result source selections
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Memory-stage transaction state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT_R = 2'b01,
    ST_DONE   = 2'b10
  } mem_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module : load_extend
//  Brief  : Picks the addressed byte/half/word out of a 32-bit read word and
//           sign- or zero-extends it according to the load funct3.
//  Rev    : 1.0  initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension
  always_comb begin
    case (offset_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   data_o = {24'd0, w_byte};
      F3_H:    data_o = {{16{w_half[15]}}, w_half};
      F3_HU:   data_o = {16'd0, w_half};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;  // illegal funct3 never reaches here (faulted)
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module : memory_access_unit
//  Brief  : RV32 memory stage. Converts load/store controls into a
//           req/gnt/rvalid data-memory transaction, steers store lanes,
//           extends load data and stalls the pipeline while busy.
//  Rev    : 1.0  initial release
// ============================================================================
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  input  logic [2:0]            funct3_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic                  mem_write_m_i,
  output logic [DATA_WIDTH-1:0] read_data_m_o,
  output logic                  stall_m_o,
  output logic                  access_fault_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  mem_state_t            state_q, state_d;
  logic [1:0]            offset_q, offset_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  w_is_store;
  logic                  w_is_load;
  logic                  w_misaligned;
  logic                  w_illegal;
  logic                  w_fault;
  logic [1:0]            w_off;
  logic [3:0]            w_store_be;
  logic [DATA_WIDTH-1:0] w_store_wdata;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_off = alu_result_m_i[1:0];

  // Extraction uses the offset/funct3 latched when the load was granted
  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .rdata_i  (dmem_rdata_i),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (w_ext)
  );

  // Access decode, alignment/funct3 legality and store lane steering
  always_comb begin
    // A store wins when both store and load controls are asserted
    w_is_store = mem_write_m_i;
    w_is_load  = !mem_write_m_i && (result_src_m_i == RES_MEM);

    w_misaligned = 1'b0;
    if (funct3_m_i[1:0] == 2'b10)      w_misaligned = (w_off != 2'b00);
    else if (funct3_m_i[1:0] == 2'b01) w_misaligned = w_off[0];

    w_illegal = 1'b0;
    if (w_is_store)
      w_illegal = !(funct3_m_i == F3_B || funct3_m_i == F3_H || funct3_m_i == F3_W);
    else if (w_is_load)
      w_illegal = (funct3_m_i == 3'b011) || (funct3_m_i == 3'b110) ||
                  (funct3_m_i == 3'b111);

    w_fault = (w_is_store || w_is_load) && (w_misaligned || w_illegal);

    w_store_be    = 4'b1111;
    w_store_wdata = '0;
    if (w_is_store) begin
      case (funct3_m_i)
        F3_B: begin
          w_store_be    = 4'b0001 << w_off;
          w_store_wdata = {4{write_data_m_i[7:0]}};
        end
        F3_H: begin
          w_store_be    = 4'b0011 << {w_off[1], 1'b0};
          w_store_wdata = {2{write_data_m_i[15:0]}};
        end
        default: begin
          w_store_be    = 4'b1111;
          w_store_wdata = write_data_m_i;
        end
      endcase
    end
  end

  // FSM next state and bus/pipeline outputs; reset forces every output low
  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    funct3_d       = funct3_q;
    result_d       = result_q;
    read_data_m_o  = '0;
    stall_m_o      = 1'b0;
    access_fault_o = 1'b0;
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    dmem_addr_o    = '0;
    dmem_be_o      = 4'b0000;
    dmem_wdata_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_fault) begin
          access_fault_o = 1'b1;
        end else if (w_is_store || w_is_load) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = w_is_store;
          dmem_addr_o  = {alu_result_m_i[ADDR_WIDTH-1:2], 2'b00};
          dmem_be_o    = w_store_be;
          dmem_wdata_o = w_store_wdata;
          stall_m_o    = !(w_is_store && dmem_gnt_i);
          if (w_is_load && dmem_gnt_i) begin
            state_d  = ST_WAIT_R;
            offset_d = w_off;
            funct3_d = funct3_m_i;
          end
        end
      end
      ST_WAIT_R: begin
        stall_m_o = 1'b1;
        if (dmem_rvalid_i) begin
          result_d = w_ext;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        read_data_m_o = result_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      read_data_m_o  = '0;
      stall_m_o      = 1'b0;
      access_fault_o = 1'b0;
      dmem_req_o     = 1'b0;
      dmem_we_o      = 1'b0;
      dmem_addr_o    = '0;
      dmem_be_o      = 4'b0000;
      dmem_wdata_o   = '0;
    end
  end

  // State and captured-load registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      offset_q <= 2'b00;
      funct3_q <= 3'b000;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      funct3_q <= funct3_d;
      result_q <= result_d;
    end
  end

endmodule : memory_access_unit
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_memory_access_unit
//  Brief  : Directed, table-driven bench for memory_access_unit with
//           hand-written multi-cycle load and reset sequences.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_m_i;
  logic [31:0] write_data_m_i;
  logic [2:0]  funct3_m_i;
  logic [1:0]  result_src_m_i;
  logic        mem_write_m_i;
  logic [31:0] read_data_m_o;
  logic        stall_m_o;
  logic        access_fault_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_total = 0;
  int n_pass  = 0;

  memory_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result_m_i (alu_result_m_i),
    .write_data_m_i (write_data_m_i),
    .funct3_m_i     (funct3_m_i),
    .result_src_m_i (result_src_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .read_data_m_o  (read_data_m_o),
    .stall_m_o      (stall_m_o),
    .access_fault_o (access_fault_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic        mw;
    logic        gnt;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_fault;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [103:0] outs();
    return {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
            stall_m_o, access_fault_o, read_data_m_o};
  endfunction

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic idle_inputs();
    alu_result_m_i = 32'h0;
    write_data_m_i = 32'h0;
    funct3_m_i     = 3'b000;
    result_src_m_i = 2'b00;
    mem_write_m_i  = 1'b0;
    dmem_gnt_i     = 1'b0;
    dmem_rvalid_i  = 1'b0;
    dmem_rdata_i   = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load: gwait cycles without grant, grant, rwait cycles without rvalid,
  // rvalid, then the DONE cycle carrying the extended result.
  task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input int gwait, input int rwait, input logic [31:0] rdata,
                          input logic [31:0] exp);
    alu_result_m_i = addr;
    funct3_m_i     = f3;
    result_src_m_i = 2'b01;
    mem_write_m_i  = 1'b0;
    write_data_m_i = 32'h5555_AAAA;
    for (int i = 0; i < gwait; i++) begin
      dmem_gnt_i = 1'b0;
      #1;
      chk({name, " no-gnt"}, outs(),
          {1'b1, 1'b0, {addr[31:2], 2'b00}, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0});
      tick();
    end
    dmem_gnt_i = 1'b1;
    #1;
    chk({name, " gnt"}, outs(),
        {1'b1, 1'b0, {addr[31:2], 2'b00}, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0});
    tick();
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < rwait; i++) begin
      dmem_rvalid_i = 1'b0;
      #1;
      chk({name, " wait-r"}, outs(), {72'h0, 1'b1, 1'b0, 32'h0});
      tick();
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    chk({name, " rvalid"}, outs(), {72'h0, 1'b1, 1'b0, 32'h0});
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'hCAFE_F00D;
    #1;
    chk({name, " done"}, outs(), {72'h0, 1'b0, 1'b0, exp});
    tick();
    idle_inputs();
    #1;
    chk({name, " after"}, outs(), 104'h0);
  endtask

  initial begin
    vecs[0]  = '{"sw 0x100",      32'h100, 32'hDEADBEEF, 3'b010, 2'b00, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1]  = '{"sb 0x103",      32'h103, 32'h123456A5, 3'b000, 2'b00, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[2]  = '{"sh 0x102",      32'h102, 32'h0000BEEF, 3'b001, 2'b00, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0};
    vecs[3]  = '{"sb 0x101",      32'h101, 32'hFFFFFF77, 3'b000, 2'b00, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h100, 4'b0010, 32'h77777777, 1'b0, 1'b0};
    vecs[4]  = '{"sh 0x200",      32'h200, 32'hABCD1234, 3'b001, 2'b00, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h200, 4'b0011, 32'h12341234, 1'b0, 1'b0};
    vecs[5]  = '{"lw misalign",   32'h102, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{"lh misalign",   32'h101, 32'h0, 3'b001, 2'b01, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
    vecs[7]  = '{"ld f3=011",     32'h100, 32'h0, 3'b011, 2'b01, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{"st f3=100",     32'h100, 32'h1, 3'b100, 2'b00, 1'b1, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
    vecs[9]  = '{"sw misalign",   32'h101, 32'h1, 3'b010, 2'b00, 1'b1, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};
    vecs[10] = '{"no access",     32'h104, 32'h1, 3'b010, 2'b10, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{"lw no gnt",     32'h200, 32'h9, 3'b010, 2'b01, 1'b0, 1'b0,
                 1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b1, 1'b0};
    vecs[12] = '{"st+ld is st",   32'h104, 32'h0BADF00D, 3'b010, 2'b01, 1'b1, 1'b1,
                 1'b1, 1'b1, 32'h104, 4'b1111, 32'h0BADF00D, 1'b0, 1'b0};
    vecs[13] = '{"sw no gnt",     32'h108, 32'h11223344, 3'b010, 2'b00, 1'b1, 1'b0,
                 1'b1, 1'b1, 32'h108, 4'b1111, 32'h11223344, 1'b1, 1'b0};
    vecs[14] = '{"lb f3=110",     32'h100, 32'h0, 3'b110, 2'b01, 1'b0, 1'b1,
                 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1};

    // Reset with a live store presented: every output must stay low
    rst = 1'b1;
    idle_inputs();
    alu_result_m_i = 32'h100;
    write_data_m_i = 32'hDEADBEEF;
    funct3_m_i     = 3'b010;
    mem_write_m_i  = 1'b1;
    dmem_gnt_i     = 1'b1;
    tick();
    tick();
    chk("reset outputs", outs(), 104'h0);
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("idle after reset", outs(), 104'h0);

    // Single-cycle IDLE behaviour: stores, faults, ungranted requests
    for (int i = 0; i < 15; i++) begin
      alu_result_m_i = vecs[i].addr;
      write_data_m_i = vecs[i].wd;
      funct3_m_i     = vecs[i].f3;
      result_src_m_i = vecs[i].rs;
      mem_write_m_i  = vecs[i].mw;
      dmem_gnt_i     = vecs[i].gnt;
      #1;
      chk(vecs[i].name, outs(),
          {vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata,
           vecs[i].e_stall, vecs[i].e_fault, 32'h0});
      tick();
      idle_inputs();
      #1;
    end

    // Multi-cycle loads
    run_load("lb 0x101",  32'h101, 3'b000, 0, 0, 32'h0000_80FF, 32'hFFFF_FF80);
    run_load("lbu 0x101", 32'h101, 3'b100, 0, 0, 32'h0000_80FF, 32'h0000_0080);
    run_load("lw gnt+3",  32'h200, 3'b010, 3, 0, 32'h1234_5678, 32'h1234_5678);
    run_load("lh 0x102",  32'h102, 3'b001, 0, 2, 32'h8001_FFFF, 32'hFFFF_8001);
    run_load("lhu 0x102", 32'h102, 3'b101, 1, 0, 32'h8001_FFFF, 32'h0000_8001);
    run_load("lb 0x103",  32'h103, 3'b000, 0, 0, 32'h7F00_0000, 32'h0000_007F);
    run_load("lh 0x100",  32'h100, 3'b001, 0, 0, 32'h1234_F00F, 32'hFFFF_F00F);

    // Reset while waiting for read data; the late response must be ignored
    alu_result_m_i = 32'h300;
    funct3_m_i     = 3'b010;
    result_src_m_i = 2'b01;
    dmem_gnt_i     = 1'b1;
    #1;
    chk("rst-seq gnt", outs(), {1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0});
    tick();
    dmem_gnt_i = 1'b0;
    rst        = 1'b1;
    #1;
    chk("rst-seq in reset", outs(), 104'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h8765_4321;
    #1;
    chk("rst-seq stale rvalid", outs(), 104'h0);
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rst-seq no done", outs(), 104'h0);
    tick();
    chk("rst-seq still idle", outs(), 104'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_memory_access_unit
`default_nettype wire
